// File: rtl/int_replay_queue_pkg.sv
// int_replay_queue_pkg: shared types, sizes and selective-flush helpers for the integer replay queue
package int_replay_queue_pkg;
    localparam int ISSUE_WIDTH = 2;
    localparam int DEPTH       = 8;
    localparam int DATA_W      = 64;
    localparam int AL_PTR_W    = 6;
    localparam int HOLD_CYCLES = 3;
    localparam int IDX_W       = $clog2(DEPTH);
    localparam int PTR_W       = IDX_W + 1;
    localparam int CNT_W       = $clog2(DEPTH + 1);
    localparam int AGE_W       = $clog2(HOLD_CYCLES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(HOLD_CYCLES);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [AL_PTR_W-1:0] al_ptr_t;
    typedef enum logic [1:0] {IDLE, WAIT, REPLAY} rq_state_e;

    typedef struct packed {
        logic [ISSUE_WIDTH-1:0]               valid;
        logic [ISSUE_WIDTH-1:0][DATA_W-1:0]   data;
        logic [ISSUE_WIDTH-1:0][AL_PTR_W-1:0] al_ptr;
        logic [AGE_W-1:0]                     age;
    } replay_group_t;

    // Circular membership in [h, t); h == t is an empty range.
    function automatic logic al_in_range(input al_ptr_t p, input al_ptr_t h, input al_ptr_t t);
        return (h <= t) ? (p >= h && p < t) : (p >= h || p < t);
    endfunction

    function automatic logic [ISSUE_WIDTH-1:0] flush_mask(
        input logic [ISSUE_WIDTH-1:0][AL_PTR_W-1:0] al,
        input logic en, input logic all, input al_ptr_t h, input al_ptr_t t);
        for (int i = 0; i < ISSUE_WIDTH; i++)
            flush_mask[i] = en && (all || al_in_range(al[i], h, t));
    endfunction
endpackage

// File: rtl/int_replay_queue_storage.sv
// int_replay_queue_storage: circular group buffer with head/tail/read pointers, per-group age and flush clear
module int_replay_queue_storage
    import int_replay_queue_pkg::*;
(
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 push_i,
    input  logic                                 pop_i,
    input  logic                                 age_i,
    input  logic                                 rd_load_i,
    input  logic                                 rd_adv_i,
    input  logic [ISSUE_WIDTH-1:0]               push_valid_i,
    input  logic [ISSUE_WIDTH-1:0][DATA_W-1:0]   push_data_i,
    input  logic [ISSUE_WIDTH-1:0][AL_PTR_W-1:0] push_al_i,
    input  logic                                 flush_i,
    input  logic                                 flush_all_i,
    input  logic [AL_PTR_W-1:0]                  flush_head_i,
    input  logic [AL_PTR_W-1:0]                  flush_tail_i,
    output logic [ISSUE_WIDTH-1:0]               rd_entry_o,
    output logic [ISSUE_WIDTH-1:0][DATA_W-1:0]   rd_data_o,
    output logic [ISSUE_WIDTH-1:0][AL_PTR_W-1:0] rd_al_o,
    output logic                                 rd_last_o,
    output logic                                 head_ripe_o,
    output cnt_t                                 count_o
);
    ptr_t head_q, tail_q, rd_q;
    replay_group_t mem_q [DEPTH];
    logic [IDX_W-1:0] head_idx, tail_idx, rd_idx;

    assign head_idx    = head_q[IDX_W-1:0];
    assign tail_idx    = tail_q[IDX_W-1:0];
    assign rd_idx      = rd_q[IDX_W-1:0];
    assign count_o     = CNT_W'(tail_q - head_q);
    assign rd_last_o   = (rd_q + 1'b1) == tail_q;
    assign head_ripe_o = mem_q[head_idx].age >= AGE_W'(HOLD_CYCLES - 1);
    assign rd_data_o   = mem_q[rd_idx].data;
    assign rd_al_o     = mem_q[rd_idx].al_ptr;
    assign rd_entry_o  = mem_q[rd_idx].valid &
                         ~flush_mask(mem_q[rd_idx].al_ptr, flush_i, flush_all_i, flush_head_i, flush_tail_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            rd_q   <= '0;
            for (int g = 0; g < DEPTH; g++) mem_q[g] <= '0;
        end else begin
            for (int g = 0; g < DEPTH; g++) begin
                mem_q[g].valid <= mem_q[g].valid &
                                  ~flush_mask(mem_q[g].al_ptr, flush_i, flush_all_i, flush_head_i, flush_tail_i);
                mem_q[g].age <= (rd_adv_i && g == int'(rd_idx)) ? '0 :
                                (age_i && mem_q[g].age != AGE_MAX) ? mem_q[g].age + 1'b1 : mem_q[g].age;
            end
            if (push_i)
                mem_q[tail_idx] <= '{valid: push_valid_i & ~flush_mask(push_al_i, flush_i, flush_all_i,
                                                                      flush_head_i, flush_tail_i),
                                     data: push_data_i, al_ptr: push_al_i, age: '0};
            head_q <= pop_i ? head_q + 1'b1 : head_q;
            tail_q <= push_i ? tail_q + 1'b1 : tail_q;
            rd_q   <= rd_load_i ? head_q : rd_adv_i ? rd_q + 1'b1 : rd_q;
        end
    end
endmodule

// File: rtl/int_replay_queue.sv
// int_replay_queue: holds issued integer groups until load hit/miss resolves and replays them after a miss
module int_replay_queue
    import int_replay_queue_pkg::*;
(
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [ISSUE_WIDTH-1:0]               issue_valid_i,
    input  logic [ISSUE_WIDTH-1:0][DATA_W-1:0]   issue_data_i,
    input  logic [ISSUE_WIDTH-1:0][AL_PTR_W-1:0] issue_al_ptr_i,
    output logic                                 can_issue_o,
    input  logic                                 load_miss_i,
    input  logic                                 mem_ready_i,
    input  logic                                 to_recovery_i,
    input  logic                                 flush_all_i,
    input  logic [AL_PTR_W-1:0]                  flush_head_i,
    input  logic [AL_PTR_W-1:0]                  flush_tail_i,
    output logic                                 replay_o,
    output logic [ISSUE_WIDTH-1:0]               replay_entry_o,
    output logic [ISSUE_WIDTH-1:0][DATA_W-1:0]   replay_data_o,
    output logic [ISSUE_WIDTH-1:0][AL_PTR_W-1:0] replay_al_ptr_o,
    output logic [CNT_W-1:0]                     count_o
);
    rq_state_e state_q;
    logic miss_q, push, pop, go_wait, rd_last, head_ripe;
    logic [ISSUE_WIDTH-1:0] rd_entry;

    assign can_issue_o    = (state_q == IDLE) && (count_o < CNT_W'(DEPTH));
    assign push           = can_issue_o && |issue_valid_i;
    // A miss counts the group pushed this cycle and beats the head's retirement.
    assign go_wait        = (state_q == IDLE) && load_miss_i && (count_o != '0 || push);
    assign pop            = (state_q == IDLE) && count_o != '0 && head_ripe && !go_wait;
    assign replay_o       = state_q == REPLAY;
    assign replay_entry_o = replay_o ? rd_entry : '0;

    int_replay_queue_storage u_storage (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .pop_i       (pop),
        .age_i       (state_q == IDLE),
        .rd_load_i   ((state_q == WAIT) && mem_ready_i),
        .rd_adv_i    (replay_o),
        .push_valid_i(issue_valid_i),
        .push_data_i (issue_data_i),
        .push_al_i   (issue_al_ptr_i),
        .flush_i     (to_recovery_i),
        .flush_all_i (flush_all_i),
        .flush_head_i(flush_head_i),
        .flush_tail_i(flush_tail_i),
        .rd_entry_o  (rd_entry),
        .rd_data_o   (replay_data_o),
        .rd_al_o     (replay_al_ptr_o),
        .rd_last_o   (rd_last),
        .head_ripe_o (head_ripe),
        .count_o     (count_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            miss_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    state_q <= go_wait ? WAIT : IDLE;
                WAIT:    state_q <= mem_ready_i ? REPLAY : WAIT;
                default: state_q <= !rd_last ? REPLAY : (miss_q || load_miss_i) ? WAIT : IDLE;
            endcase
            miss_q <= replay_o && !rd_last && (miss_q || load_miss_i);
        end
    end

    issue_when_blocked: assert property (@(posedge clk_i) disable iff (!rst_ni) !(|issue_valid_i && !can_issue_o))
        else $warning("issue while can_issue is low is dropped");
endmodule

// File: tb/tb_int_replay_queue.sv
// tb_int_replay_queue: directed scenarios for the integer replay queue with hand-computed expectations
module tb_int_replay_queue;
    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic [1:0] issue_valid, replay_entry;
    logic [127:0] issue_data, replay_data;
    logic [11:0] issue_al, replay_al;
    logic can_issue, load_miss, mem_ready, to_recovery, flush_all, replay;
    logic [5:0] flush_head, flush_tail;
    logic [3:0] count;
    int vec = 0, bad = 0;

    always #5 clk_i = ~clk_i;

    int_replay_queue dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .issue_valid_i(issue_valid), .issue_data_i(issue_data),
        .issue_al_ptr_i(issue_al), .can_issue_o(can_issue), .load_miss_i(load_miss), .mem_ready_i(mem_ready),
        .to_recovery_i(to_recovery), .flush_all_i(flush_all), .flush_head_i(flush_head), .flush_tail_i(flush_tail),
        .replay_o(replay), .replay_entry_o(replay_entry), .replay_data_o(replay_data),
        .replay_al_ptr_o(replay_al), .count_o(count)
    );

    task automatic clr();
        issue_valid = '0; issue_data = '0; issue_al = '0; load_miss = 0; mem_ready = 0;
        to_recovery = 0; flush_all = 0; flush_head = '0; flush_tail = '0;
    endtask

    task automatic iss(input logic [1:0] v, input logic [5:0] a0, input logic [5:0] a1);
        issue_valid = v; issue_al = {a1, a0};
        issue_data = {64'hB000 + 64'(a1), 64'hA000 + 64'(a0)};
    endtask

    // Advance to just after the next rising edge, then drop all inputs.
    task automatic tick();
        @(posedge clk_i); #1; clr();
    endtask

    task automatic test_reset();
        clr(); rst_ni = 0; #3;
        vec++; if (replay !== 1'b0) begin bad++; $display("FAIL reset_replay got %b exp 0", replay); end
        vec++; if (replay_entry !== 2'b00) begin bad++; $display("FAIL reset_entry got %b exp 00", replay_entry); end
        vec++; if (can_issue !== 1'b1) begin bad++; $display("FAIL reset_can_issue got %b exp 1", can_issue); end
        vec++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got %0d exp 0", count); end
        @(posedge clk_i); #3; rst_ni = 1; tick();
    endtask

    task automatic test_retire();
        test_reset();
        iss(2'b11, 6'd1, 6'd2); tick();
        for (int c = 1; c <= 3; c++) begin
            #1;
            vec++; if (count !== 4'd1) begin bad++; $display("FAIL retire_count c%0d got %0d exp 1", c, count); end
            vec++; if (replay !== 1'b0) begin bad++; $display("FAIL retire_replay c%0d got %b exp 0", c, replay); end
            tick();
        end
        #1;
        vec++; if (count !== 4'd0) begin bad++; $display("FAIL retire_gone got %0d exp 0", count); end
        vec++; if (can_issue !== 1'b1) begin bad++; $display("FAIL retire_can_issue got %b exp 1", can_issue); end
    endtask

    task automatic test_replay_order();
        test_reset();
        for (int c = 0; c < 3; c++) begin iss(2'b01, 6'(c + 1), 6'd0); tick(); end
        load_miss = 1; tick();
        #1;
        vec++; if (can_issue !== 1'b0) begin bad++; $display("FAIL order_wait_can_issue got %b exp 0", can_issue); end
        vec++; if (count !== 4'd3) begin bad++; $display("FAIL order_wait_count got %0d exp 3", count); end
        tick(); tick();
        mem_ready = 1; tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            vec++; if (replay !== 1'b1) begin bad++; $display("FAIL order_replay g%0d got %b exp 1", k, replay); end
            vec++; if (replay_al[5:0] !== 6'(k + 1)) begin bad++; $display("FAIL order_al g%0d got %0d exp %0d", k, replay_al[5:0], k + 1); end
            vec++; if (replay_data[63:0] !== 64'hA000 + 64'(k + 1)) begin bad++; $display("FAIL order_data g%0d got %h exp %h", k, replay_data[63:0], 64'hA000 + 64'(k + 1)); end
            vec++; if (replay_entry !== 2'b01) begin bad++; $display("FAIL order_entry g%0d got %b exp 01", k, replay_entry); end
            tick();
        end
        #1;
        vec++; if (replay !== 1'b0) begin bad++; $display("FAIL order_end_replay got %b exp 0", replay); end
        vec++; if (can_issue !== 1'b1) begin bad++; $display("FAIL order_end_can_issue got %b exp 1", can_issue); end
        vec++; if (count !== 4'd3) begin bad++; $display("FAIL order_end_count got %0d exp 3", count); end
    endtask

    task automatic test_miss_pop();
        test_reset();
        iss(2'b11, 6'd4, 6'd8); tick(); tick(); tick();
        load_miss = 1; tick();
        for (int c = 4; c < 7; c++) begin
            #1;
            vec++; if (count !== 4'd1) begin bad++; $display("FAIL collide_count c%0d got %0d exp 1", c, count); end
            vec++; if (can_issue !== 1'b0) begin bad++; $display("FAIL collide_can_issue c%0d got %b exp 0", c, can_issue); end
            tick();
        end
        mem_ready = 1; tick(); #1;
        vec++; if (replay_entry !== 2'b11) begin bad++; $display("FAIL collide_entry got %b exp 11", replay_entry); end
        vec++; if (replay_al !== {6'd8, 6'd4}) begin bad++; $display("FAIL collide_al got %h exp %h", replay_al, {6'd8, 6'd4}); end
        tick(); #1;
        vec++; if (can_issue !== 1'b1) begin bad++; $display("FAIL collide_idle got %b exp 1", can_issue); end
    endtask

    task automatic test_selective_flush();
        logic [1:0] exp_e [3] = '{2'b01, 2'b00, 2'b01};
        test_reset();
        for (int c = 0; c < 3; c++) begin iss(2'b01, 6'(c + 5), 6'd0); tick(); end
        load_miss = 1; tick();
        to_recovery = 1; flush_head = 6'd6; flush_tail = 6'd7; tick();
        mem_ready = 1; tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            vec++; if (replay !== 1'b1) begin bad++; $display("FAIL sel_replay g%0d got %b exp 1", k, replay); end
            vec++; if (replay_entry !== exp_e[k]) begin bad++; $display("FAIL sel_entry g%0d got %b exp %b", k, replay_entry, exp_e[k]); end
            vec++; if (replay_al[5:0] !== 6'(k + 5)) begin bad++; $display("FAIL sel_al g%0d got %0d exp %0d", k, replay_al[5:0], k + 5); end
            tick();
        end
    endtask

    task automatic test_flush_edges();
        test_reset();
        iss(2'b11, 6'd5, 6'd5); to_recovery = 1; flush_all = 1; tick();
        iss(2'b11, 6'd63, 6'd10); to_recovery = 1; flush_head = 6'd9; flush_tail = 6'd9; tick();
        iss(2'b11, 6'd63, 6'd10); tick();
        load_miss = 1; tick();
        to_recovery = 1; flush_head = 6'd60; flush_tail = 6'd2; mem_ready = 1; tick();
        #1;
        vec++; if (replay_entry !== 2'b00) begin bad++; $display("FAIL edge_flush_all_push got %b exp 00", replay_entry); end
        tick(); #1;
        vec++; if (replay_entry !== 2'b10) begin bad++; $display("FAIL edge_wrap_range got %b exp 10", replay_entry); end
        tick();
        to_recovery = 1; flush_head = 6'd10; flush_tail = 6'd11; #1;
        vec++; if (replay_entry !== 2'b00) begin bad++; $display("FAIL edge_comb_mask got %b exp 00", replay_entry); end
        vec++; if (replay !== 1'b1) begin bad++; $display("FAIL edge_comb_replay got %b exp 1", replay); end
        tick(); #1;
        vec++; if (replay !== 1'b0) begin bad++; $display("FAIL edge_end_replay got %b exp 0", replay); end
        vec++; if (count !== 4'd3) begin bad++; $display("FAIL edge_end_count got %0d exp 3", count); end
    endtask

    task automatic test_back_to_back();
        test_reset();
        iss(2'b01, 6'd1, 6'd0); tick();
        iss(2'b01, 6'd2, 6'd0); tick();
        load_miss = 1; tick();
        mem_ready = 1; tick();
        load_miss = 1; tick();
        tick(); #1;
        vec++; if (replay !== 1'b0) begin bad++; $display("FAIL b2b_wait_replay got %b exp 0", replay); end
        vec++; if (can_issue !== 1'b0) begin bad++; $display("FAIL b2b_wait_can_issue got %b exp 0", can_issue); end
        vec++; if (count !== 4'd2) begin bad++; $display("FAIL b2b_wait_count got %0d exp 2", count); end
        mem_ready = 1; tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            vec++; if (replay_al[5:0] !== 6'(k + 1)) begin bad++; $display("FAIL b2b_al g%0d got %0d exp %0d", k, replay_al[5:0], k + 1); end
            tick();
        end
        #1;
        vec++; if (can_issue !== 1'b1) begin bad++; $display("FAIL b2b_idle got %b exp 1", can_issue); end
    endtask

    task automatic test_full();
        test_reset();
        // Each round pushes one group together with a miss, then replays everything held.
        for (int k = 1; k <= 8; k++) begin
            #1;
            vec++; if (can_issue !== 1'b1) begin bad++; $display("FAIL full_round_can_issue k%0d got %b exp 1", k, can_issue); end
            iss(2'b01, 6'(k), 6'd0); load_miss = 1; tick();
            mem_ready = 1; tick();
            for (int j = 0; j < k; j++) tick();
        end
        #1;
        vec++; if (count !== 4'd8) begin bad++; $display("FAIL full_count got %0d exp 8", count); end
        vec++; if (can_issue !== 1'b0) begin bad++; $display("FAIL full_can_issue got %b exp 0", can_issue); end
        iss(2'b01, 6'd9, 6'd0); tick(); #1;
        vec++; if (count !== 4'd8) begin bad++; $display("FAIL full_ignored got %0d exp 8", count); end
        tick(); tick(); #1;
        vec++; if (count !== 4'd7) begin bad++; $display("FAIL full_pop got %0d exp 7", count); end
        vec++; if (can_issue !== 1'b1) begin bad++; $display("FAIL full_reopen got %b exp 1", can_issue); end
    endtask

    task automatic test_async_reset();
        test_reset();
        iss(2'b11, 6'd1, 6'd2); tick();
        iss(2'b11, 6'd3, 6'd4); tick();
        load_miss = 1; tick();
        mem_ready = 1; tick();
        #1;
        vec++; if (replay !== 1'b1) begin bad++; $display("FAIL arst_pre_replay got %b exp 1", replay); end
        #2; rst_ni = 0; #1;
        vec++; if (replay !== 1'b0) begin bad++; $display("FAIL arst_replay got %b exp 0", replay); end
        vec++; if (count !== 4'd0) begin bad++; $display("FAIL arst_count got %0d exp 0", count); end
        vec++; if (can_issue !== 1'b1) begin bad++; $display("FAIL arst_can_issue got %b exp 1", can_issue); end
        #2; rst_ni = 1; tick(); #1;
        vec++; if (replay !== 1'b0 || can_issue !== 1'b1) begin bad++; $display("FAIL arst_idle got replay=%b can_issue=%b exp 0/1", replay, can_issue); end
    endtask

    initial begin
        test_reset();
        test_retire();
        test_replay_order();
        test_miss_pop();
        test_selective_flush();
        test_flush_edges();
        test_back_to_back();
        test_full();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
